grf_bank: RTL and testbench

General-purpose register file for the five-stage MIPS pipeline: 32 × 32-bit registers, two combinational read ports feeding the Decode stage, one synchronous write port driven by the Write-Back stage's enable/address/data triple. Provides optional write-to-read bypass so that Decode sees a value Write-Back is committing in the same cycle. Also keeps a committed-write counter for testbench retirement checking.

---
 rtl/grf_bank.sv | 103 ++++++++++
 tb/tb_grf_bank.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/grf_bank.sv
// grf_bank: 32 x 32-bit general-purpose register file for the MIPS pipeline.
// Two combinational read ports (Decode) and one synchronous write port (Write-Back).
// r0 has no storage and always reads zero. A committed-write counter tracks
// writes that actually changed architectural state (non-zero destination).
// Optional feature: define GRF_BYPASS_EN to forward the write triple presented
// in the current cycle straight to any read port addressing the same register.
module grf_bank #(
  parameter logic [31:0] GP_INIT = 32'h0000_1800,
  parameter logic [31:0] SP_INIT = 32'h0000_2ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  GRF_read_addr1,
  input  logic [4:0]  GRF_read_addr2,
  output logic [31:0] GRF_read_data1,
  output logic [31:0] GRF_read_data2,
  input  logic        GRF_write_enable,
  input  logic [4:0]  GRF_write_addr,
  input  logic [31:0] GRF_write_data,
  output logic [31:0] write_count
);

  // Architectural storage for r1..r31; r0 is hardwired and has no flops.
  logic [31:0] regs_q [1:31];
  logic [31:0] count_q;
  logic [31:0] count_d;
  logic        write_hit_s;
  logic [31:0] rd1_s;
  logic [31:0] rd2_s;

  // A write only counts when it targets a real register.
  always_comb begin
    write_hit_s = GRF_write_enable && (GRF_write_addr != 5'd0);
  end

  // Counter next state: unsigned increment, wraps silently.
  always_comb begin
    if (write_hit_s) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Register array: async reset to architectural defaults, commit on rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        if (i == 32'sd28) begin
          regs_q[i] <= GP_INIT;
        end else if (i == 32'sd29) begin
          regs_q[i] <= SP_INIT;
        end else begin
          regs_q[i] <= 32'h0000_0000;
        end
      end
    end else if (write_hit_s) begin
      regs_q[GRF_write_addr] <= GRF_write_data;
    end
  end

  // Committed-write counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 32'h0000_0000;
    end else begin
      count_q <= count_d;
    end
  end

  // Read port 1: zero for r0, optionally forwarded, otherwise stored contents.
  always_comb begin
    rd1_s = 32'h0000_0000;
    if (GRF_read_addr1 == 5'd0) begin
      rd1_s = 32'h0000_0000;
`ifdef GRF_BYPASS_EN
    end else if (write_hit_s && (GRF_write_addr == GRF_read_addr1)) begin
      rd1_s = GRF_write_data;
`endif
    end else begin
      rd1_s = regs_q[GRF_read_addr1];
    end
  end

  // Read port 2: evaluated independently of port 1.
  always_comb begin
    rd2_s = 32'h0000_0000;
    if (GRF_read_addr2 == 5'd0) begin
      rd2_s = 32'h0000_0000;
`ifdef GRF_BYPASS_EN
    end else if (write_hit_s && (GRF_write_addr == GRF_read_addr2)) begin
      rd2_s = GRF_write_data;
`endif
    end else begin
      rd2_s = regs_q[GRF_read_addr2];
    end
  end

  assign GRF_read_data1 = rd1_s;
  assign GRF_read_data2 = rd2_s;
  assign write_count    = count_q;

endmodule

// File: tb/tb_grf_bank.sv
// Self-checking bench for grf_bank: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an array-based model.
module tb_grf_bank;

`ifdef GRF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  ra1 = 5'd0, ra2 = 5'd0, wa = 5'd0;
  logic [31:0] rd1, rd2, wd = 32'h0, wcnt;
  logic        we = 1'b0;
  bit          cmp_en = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_regs [0:31];
  logic [31:0] m_count;

  grf_bank dut (
    .clk(clk), .reset(reset),
    .GRF_read_addr1(ra1), .GRF_read_addr2(ra2),
    .GRF_read_data1(rd1), .GRF_read_data2(rd2),
    .GRF_write_enable(we), .GRF_write_addr(wa), .GRF_write_data(wd),
    .write_count(wcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_regs[28] = 32'h0000_1800;
    m_regs[29] = 32'h0000_2ffc;
    m_count = 32'h0;
  endtask

  function automatic logic [31:0] expect_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYP && we && wa != 5'd0 && wa == a) return wd;
    return m_regs[a];
  endfunction

  // Model commit: what the register file must hold after each edge.
  always @(posedge clk) begin
    if (!reset && we && wa != 5'd0) begin
      m_regs[wa] = wd;
      m_count = m_count + 32'd1;
    end
  end

  // Per-cycle compare, mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rd1", rd1, expect_rd(ra1));
      chk("rd2", rd2, expect_rd(ra2));
      chk("count", wcnt, m_count);
    end
  end

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    cyc();
    we = 1'b0;
  endtask

  initial begin
    model_reset();
    cyc();
    reset = 1'b0;
    cmp_en = 1'b1;

    // Reset defaults.
    ra1 = 5'd28; ra2 = 5'd29; #1;
    chk("rst_gp", rd1, 32'h0000_1800);
    chk("rst_sp", rd2, 32'h0000_2ffc);
    chk("rst_cnt", wcnt, 32'h0);

    // Basic write/read on both ports.
    wr(5'd7, 32'hDEAD_BEEF);
    ra1 = 5'd7; ra2 = 5'd7; #1;
    chk("r7_p1", rd1, 32'hDEAD_BEEF);
    chk("r7_p2", rd2, 32'hDEAD_BEEF);
    chk("cnt_1", wcnt, 32'd1);

    // r0 protection.
    wr(5'd0, 32'h1234_5678);
    ra1 = 5'd0; #1;
    chk("r0_zero", rd1, 32'h0);
    chk("cnt_r0", wcnt, 32'd1);

    // Bypass vs stored-value behaviour.
    wr(5'd9, 32'h0000_0099);
    we = 1'b1; wa = 5'd9; wd = 32'hCAFE_0001; ra1 = 5'd9; ra2 = 5'd0; #1;
    chk("byp_pre", rd1, BYP ? 32'hCAFE_0001 : 32'h0000_0099);
    chk("byp_r0", rd2, 32'h0);
    cyc();
    we = 1'b0; #1;
    chk("byp_post", rd1, 32'hCAFE_0001);
    chk("cnt_byp", wcnt, 32'd3);

    // Disabled write for 4 edges.
    we = 1'b0; wa = 5'd3; wd = 32'hFFFF_FFFF; ra1 = 5'd3;
    repeat (4) cyc();
    #1;
    chk("dis_r3", rd1, 32'h0);
    chk("dis_cnt", wcnt, 32'd3);

    // Asynchronous reset mid-cycle after writing r5.
    wr(5'd5, 32'h0000_0055);
    ra1 = 5'd5; #1;
    chk("r5_set", rd1, 32'h0000_0055);
    #1;
    reset = 1'b1; model_reset(); #1;
    chk("rst_r5", rd1, 32'h0);
    chk("rst_cnt2", wcnt, 32'h0);
    cyc();
    reset = 1'b0;

    // 32 sequential writes -> count 32.
    for (int i = 1; i < 32; i++) wr(5'(i), 32'h100 + 32'(i));
    wr(5'd1, 32'hAAAA_0001);
    #1;
    chk("cnt_32", wcnt, 32'd32);

    // Counter wrap via deposit.
    dut.count_q = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    wr(5'd4, 32'h0000_0004);
    #1;
    chk("cnt_wrap", wcnt, 32'h0);

    // Randomized traffic, occasional reset.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        #1;
        reset = 1'b1; model_reset();
        cyc();
        reset = 1'b0;
      end else begin
        we  = 1'($urandom_range(0, 3) != 0);
        wa  = 5'($urandom_range(0, 31));
        wd  = $urandom;
        ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
        ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
        cyc();
      end
    end

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
